regfile_sb: RTL and testbench

Parametrised multi-port integer register file with a write-to-read bypass and a per-register pending-write scoreboard. It supports NR_RD read ports and NR_WR write ports. It sits in the decode/writeback boundary of the RISC-V core. Decode reads operands and marks destination registers pending on issue. Writeback ports (ALU, load unit) write results and clear the pending marks, so decode can stall on load-use and multi-cycle hazards.

---
 rtl/regfile_sb.sv | 125 ++++++++++++
 tb/tb_regfile_sb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-to-read bypass and pending-write scoreboard.
// Latency: reads combinational (0 cycles with bypass, 1 without); busy/count registered, 1 cycle.
// Backpressure: none; every enabled write, issue and flush is consumed in the cycle presented.
module regfile_sb #(
    parameter int W      = 32,
    parameter int NU_REG = 5,
    parameter int NR_RD  = 2,
    parameter int NR_WR  = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NR_WR-1:0]         wr_en_i,
    input  logic [NR_WR*NU_REG-1:0]  wr_addr_i,
    input  logic [NR_WR*W-1:0]       wr_data_i,
    input  logic [NR_RD*NU_REG-1:0]  rd_addr_i,
    output logic [NR_RD*W-1:0]       rd_data_o,
    output logic [NR_RD-1:0]         rd_busy_o,
    input  logic                     iss_en_i,
    input  logic [NU_REG-1:0]        iss_addr_i,
    input  logic                     flush_i,
    output logic [2**NU_REG-1:0]     busy_o,
    output logic [NU_REG:0]          busy_cnt_o
);

    localparam int NREG = 2**NU_REG;

    logic [W-1:0]      mem_q [NREG];
    logic [W-1:0]      mem_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [NU_REG:0]   busy_cnt_q;
    logic [NU_REG:0]   busy_cnt_d;

    logic [NU_REG-1:0] wa [NR_WR];
    logic [W-1:0]      wd [NR_WR];
    logic [NREG-1:0]   wr_hit;

    // Unpack write ports and flag every register targeted by an enabled nonzero write.
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NR_WR; k++) begin
            wa[k] = wr_addr_i[k*NU_REG +: NU_REG];
            wd[k] = wr_data_i[k*W +: W];
            if (wr_en_i[k] && (wa[k] != '0)) begin
                wr_hit[wa[k]] = 1'b1;
            end
        end
    end

    // Next storage: ascending port order so the highest-index port's data lands last.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NR_WR; k++) begin
            if (wr_en_i[k] && (wa[k] != '0)) begin
                mem_d[wa[k]] = wd[k];
            end
        end
        mem_d[0] = '0;
    end

    // Next scoreboard: writeback clears, flush clears all, a new issue wins over both.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (flush_i) begin
            busy_d = '0;
        end
        if (iss_en_i) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        busy_cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_cnt_d = busy_cnt_d + (NU_REG+1)'(busy_d[r]);
        end
    end

    // Read ports: registered state, optionally overridden by same-cycle write data and busy-clear.
    always_comb begin
        logic [NU_REG-1:0] ra;
        logic [W-1:0]      data;
        logic              hit;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NR_RD; i++) begin
            ra   = rd_addr_i[i*NU_REG +: NU_REG];
            data = mem_q[ra];
            hit  = 1'b0;
            if (BYPASS != 0) begin
                for (int k = 0; k < NR_WR; k++) begin
                    if (wr_en_i[k] && (wa[k] == ra)) begin
                        data = wd[k];
                        hit  = 1'b1;
                    end
                end
            end
            if (ra == '0) begin
                rd_data_o[i*W +: W] = '0;
                rd_busy_o[i]        = 1'b0;
            end else begin
                rd_data_o[i*W +: W] = data;
                rd_busy_o[i]        = busy_q[ra] & ~hit;
            end
        end
    end

    // State registers; reset discards any operation presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypass and a non-bypass instance share stimulus.
// Directed table of expected values, hand sequences for the non-bypass variant,
// then random traffic checked against an array-based reference model.
module tb_regfile_sb;

    localparam int W    = 32;
    localparam int NU   = 5;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NWR-1:0]    we;
    logic [NWR*NU-1:0] wa;
    logic [NWR*W-1:0]  wd;
    logic [NRD*NU-1:0] ra;
    logic              ie;
    logic [NU-1:0]     ia;
    logic              fl;

    logic [NRD*W-1:0]  a_rd, b_rd;
    logic [NRD-1:0]    a_rb, b_rb;
    logic [NREG-1:0]   a_busy, b_busy;
    logic [NU:0]       a_cnt, b_cnt;

    regfile_sb #(.W(W), .NU_REG(NU), .NR_RD(NRD), .NR_WR(NWR), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
        .rd_addr_i(ra), .rd_data_o(a_rd), .rd_busy_o(a_rb), .iss_en_i(ie),
        .iss_addr_i(ia), .flush_i(fl), .busy_o(a_busy), .busy_cnt_o(a_cnt)
    );

    regfile_sb #(.W(W), .NU_REG(NU), .NR_RD(NRD), .NR_WR(NWR), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
        .rd_addr_i(ra), .rd_data_o(b_rd), .rd_busy_o(b_rb), .iss_en_i(ie),
        .iss_addr_i(ia), .flush_i(fl), .busy_o(b_busy), .busy_cnt_o(b_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural contents and pending flags.
    logic [W-1:0] m_mem [NREG];
    bit           m_busy [NREG];

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [31:0] e_rd0, e_rd1;
        logic [1:0]  e_rb;
        logic [31:0] e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [15];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] v_we, v_wa0, v_wd0, v_wa1, v_wd1,
                                v_ra0, v_ra1, v_ie, v_ia, v_fl,
                                v_rd0, v_rd1, v_rb, v_busy, v_cnt);
        vec_t v;
        v.we = v_we[1:0];   v.wa0 = v_wa0[4:0]; v.wd0 = v_wd0;
        v.wa1 = v_wa1[4:0]; v.wd1 = v_wd1;
        v.ra0 = v_ra0[4:0]; v.ra1 = v_ra1[4:0];
        v.ie = v_ie[0];     v.ia = v_ia[4:0];   v.fl = v_fl[0];
        v.e_rd0 = v_rd0;    v.e_rd1 = v_rd1;    v.e_rb = v_rb[1:0];
        v.e_busy = v_busy;  v.e_cnt = v_cnt[5:0];
        return v;
    endfunction

    // Expected read data: x0 is zero; with bypass the highest-index matching write wins.
    function automatic logic [W-1:0] exp_rd(input logic [NU-1:0] a, input bit byp);
        if (a == '0) return '0;
        if (byp) begin
            for (int k = NWR - 1; k >= 0; k--) begin
                if (we[k] && wa[k*NU +: NU] == a) return wd[k*W +: W];
            end
        end
        return m_mem[a];
    endfunction

    function automatic logic exp_rb(input logic [NU-1:0] a, input bit byp);
        if (a == '0) return 1'b0;
        if (byp) begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && wa[k*NU +: NU] == a) return 1'b0;
            end
        end
        return m_busy[a];
    endfunction

    function automatic logic [NREG-1:0] exp_busy();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic logic [NU:0] exp_cnt();
        int c = 0;
        for (int r = 0; r < NREG; r++) if (m_busy[r]) c++;
        return (NU+1)'(c);
    endfunction

    task automatic model_check();
        logic [NU-1:0] a;
        for (int i = 0; i < NRD; i++) begin
            a = ra[i*NU +: NU];
            cmp($sformatf("byp_rd_data[%0d] x%0d", i, a), a_rd[i*W +: W], exp_rd(a, 1'b1));
            cmp($sformatf("nobyp_rd_data[%0d] x%0d", i, a), b_rd[i*W +: W], exp_rd(a, 1'b0));
            cmp($sformatf("byp_rd_busy[%0d] x%0d", i, a), a_rb[i], exp_rb(a, 1'b1));
            cmp($sformatf("nobyp_rd_busy[%0d] x%0d", i, a), b_rb[i], exp_rb(a, 1'b0));
        end
        cmp("byp_busy_o", a_busy, exp_busy());
        cmp("nobyp_busy_o", b_busy, exp_busy());
        cmp("byp_busy_cnt", a_cnt, exp_cnt());
        cmp("nobyp_busy_cnt", b_cnt, exp_cnt());
    endtask

    // Advance the model by one clock edge from the rules for writes, issue, flush and reset.
    task automatic model_update();
        logic [W-1:0] nm [NREG];
        bit           nb [NREG];
        bit           hit;
        for (int r = 0; r < NREG; r++) begin
            nm[r] = m_mem[r];
            nb[r] = m_busy[r];
        end
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                nm[r] = '0;
                nb[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                hit = 1'b0;
                for (int k = NWR - 1; k >= 0; k--) begin
                    if (!hit && we[k] && wa[k*NU +: NU] == NU'(r)) begin
                        nm[r] = wd[k*W +: W];
                        hit   = 1'b1;
                    end
                end
                if (ie && ia == NU'(r))  nb[r] = 1'b1;
                else if (fl)             nb[r] = 1'b0;
                else if (hit)            nb[r] = 1'b0;
            end
        end
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = nm[r];
            m_busy[r] = nb[r];
        end
    endtask

    task automatic sample(input bit chk);
        @(negedge clk);
        if (chk) model_check();
    endtask

    task automatic finish_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = '0; wa = '0; wd = '0; ie = 1'b0; ia = '0; fl = 1'b0;
    endtask

    initial begin
        idle();
        ra = '0;
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end

        // Reset for two cycles with writes and issue presented; they must be discarded.
        rst = 1'b1; we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'h0BAD_0002, 32'h0BAD_0001};
        ie = 1'b1; ia = 5'd1;
        sample(1'b0); finish_cycle();
        sample(1'b0); finish_cycle();
        idle();

        for (int r = 0; r < NREG; r++) begin
            ra = {5'(NREG - 1 - r), 5'(r)};
            sample(1'b1);
            cmp($sformatf("reset_rd x%0d", r), a_rd, 64'h0);
            cmp($sformatf("reset_rd_nobyp x%0d", r), b_rd, 64'h0);
            if (r == 0) begin
                cmp("reset_busy_o", a_busy, 64'h0);
                cmp("reset_busy_cnt", a_cnt, 64'h0);
            end
            finish_cycle();
        end

        //             we  wa0 wd0           wa1 wd1   ra0 ra1 ie ia fl  rd0           rd1           rb     busy     cnt
        tbl[0]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0,     0, 5,  0, 0, 0,  0,            32'hDEADBEEF, 2'b00, 32'h0,   0);
        tbl[1]  = mk(2'b00, 0, 0,            0, 0,     5, 0,  0, 0, 0,  32'hDEADBEEF, 0,            2'b00, 32'h0,   0);
        tbl[2]  = mk(2'b01, 0, 32'h1234,     0, 0,     0, 0,  0, 0, 0,  0,            0,            2'b00, 32'h0,   0);
        tbl[3]  = mk(2'b00, 0, 0,            0, 0,     0, 0,  0, 0, 0,  0,            0,            2'b00, 32'h0,   0);
        tbl[4]  = mk(2'b11, 7, 32'h11,       7, 32'h22, 7, 7, 0, 0, 0,  32'h22,       32'h22,       2'b00, 32'h0,   0);
        tbl[5]  = mk(2'b00, 0, 0,            0, 0,     7, 5,  0, 0, 0,  32'h22,       32'hDEADBEEF, 2'b00, 32'h0,   0);
        tbl[6]  = mk(2'b00, 0, 0,            0, 0,     3, 7,  1, 3, 0,  0,            32'h22,       2'b00, 32'h0,   0);
        tbl[7]  = mk(2'b00, 0, 0,            0, 0,     3, 3,  0, 0, 0,  0,            0,            2'b11, 32'h8,   1);
        tbl[8]  = mk(2'b01, 3, 32'h55,       0, 0,     3, 3,  0, 0, 0,  32'h55,       32'h55,       2'b00, 32'h8,   1);
        tbl[9]  = mk(2'b00, 0, 0,            0, 0,     3, 3,  0, 0, 0,  32'h55,       32'h55,       2'b00, 32'h0,   0);
        tbl[10] = mk(2'b01, 4, 32'h44,       0, 0,     4, 4,  1, 4, 0,  32'h44,       32'h44,       2'b00, 32'h0,   0);
        tbl[11] = mk(2'b00, 0, 0,            0, 0,     4, 4,  0, 0, 0,  32'h44,       32'h44,       2'b11, 32'h10,  1);
        tbl[12] = mk(2'b00, 0, 0,            0, 0,     4, 6,  1, 6, 0,  32'h44,       0,            2'b01, 32'h10,  1);
        tbl[13] = mk(2'b00, 0, 0,            0, 0,     4, 6,  1, 9, 1,  32'h44,       0,            2'b11, 32'h50,  2);
        tbl[14] = mk(2'b00, 0, 0,            0, 0,     9, 4,  0, 0, 0,  0,            32'h44,       2'b01, 32'h200, 1);

        for (int t = 0; t < 15; t++) begin
            idle();
            we = tbl[t].we;
            wa = {tbl[t].wa1, tbl[t].wa0};
            wd = {tbl[t].wd1, tbl[t].wd0};
            ra = {tbl[t].ra1, tbl[t].ra0};
            ie = tbl[t].ie; ia = tbl[t].ia; fl = tbl[t].fl;
            sample(1'b1);
            cmp($sformatf("vec%0d rd0", t), a_rd[31:0], tbl[t].e_rd0);
            cmp($sformatf("vec%0d rd1", t), a_rd[63:32], tbl[t].e_rd1);
            cmp($sformatf("vec%0d rd_busy", t), a_rb, tbl[t].e_rb);
            cmp($sformatf("vec%0d busy_o", t), a_busy, tbl[t].e_busy);
            cmp($sformatf("vec%0d busy_cnt", t), a_cnt, tbl[t].e_cnt);
            finish_cycle();
        end

        // Non-bypass instance: write is seen only after the edge, busy clears only at the edge.
        idle(); ra = {5'd10, 5'd10};
        we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'h0, 32'hA5A5A5A5};
        sample(1'b1);
        cmp("nobyp same-cycle write x10", b_rd[31:0], 64'h0);
        cmp("byp same-cycle write x10", a_rd[31:0], 64'hA5A5A5A5);
        finish_cycle();
        idle();
        sample(1'b1);
        cmp("nobyp next-cycle read x10", b_rd[31:0], 64'hA5A5A5A5);
        finish_cycle();
        ie = 1'b1; ia = 5'd10;
        sample(1'b1); finish_cycle();
        idle();
        sample(1'b1);
        cmp("nobyp busy after issue x10", b_rb[0], 64'h1);
        finish_cycle();
        we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'h0, 32'h5};
        sample(1'b1);
        cmp("nobyp busy during writeback", b_rb[0], 64'h1);
        cmp("byp busy during writeback", a_rb[0], 64'h0);
        cmp("nobyp old data during writeback", b_rd[31:0], 64'hA5A5A5A5);
        finish_cycle();
        idle();
        sample(1'b1);
        cmp("nobyp busy after writeback", b_rb[0], 64'h0);
        cmp("nobyp data after writeback", b_rd[31:0], 64'h5);
        finish_cycle();

        // Random traffic; narrow address range half the time to force collisions.
        for (int n = 0; n < 600; n++) begin
            bit narrow;
            narrow = $urandom_range(1) == 0;
            rst = $urandom_range(63) == 0;
            we  = 2'($urandom);
            for (int k = 0; k < NWR; k++) begin
                wa[k*NU +: NU] = narrow ? 5'($urandom_range(7)) : 5'($urandom);
                wd[k*W +: W]   = $urandom;
            end
            for (int i = 0; i < NRD; i++) begin
                ra[i*NU +: NU] = narrow ? 5'($urandom_range(7)) : 5'($urandom);
            end
            ie = $urandom_range(2) == 0;
            ia = narrow ? 5'($urandom_range(7)) : 5'($urandom);
            fl = $urandom_range(15) == 0;
            sample(1'b1);
            finish_cycle();
        end

        idle();
        sample(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
